// File: rtl/sargantana_icache_refill_unit_if.sv
// ---------------------------------------------------------------------------
// sargantana_icache_refill_unit_if
//
// Bundles the miss hand-off from the icache control logic and the iFill bus
// towards the upper memory levels into one interface.
//
// Signals (directions as seen from the refill unit, modport master):
//   miss_valid      in   miss request from icache control
//   miss_ready      out  refill unit idle, miss accepted on valid && ready
//   miss_paddr      in   missing physical address
//   miss_way        in   victim way
//   req_valid       out  iFill request, held until acked
//   req_paddr       out  line-aligned request address
//   req_way         out  victim way of the request
//   resp_ack        in   request accepted by the upper level
//   resp_valid      in   beat valid
//   resp_beat       in   beat index within the line
//   resp_data       in   beat data
//   resp_inv_valid  in   coherence invalidation valid
//   resp_inv_paddr  in   invalidation address
//
// The slave modport is the environment side: icache control plus upper level.
// ---------------------------------------------------------------------------
interface sargantana_icache_refill_unit_if #(
    parameter int PADDR_SIZE = 40,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int WAYS       = 4
);
    localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_BITS = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    logic                  miss_valid;
    logic                  miss_ready;
    logic [PADDR_SIZE-1:0] miss_paddr;
    logic [WAY_BITS-1:0]   miss_way;

    logic                  req_valid;
    logic [PADDR_SIZE-1:0] req_paddr;
    logic [WAY_BITS-1:0]   req_way;

    logic                  resp_ack;
    logic                  resp_valid;
    logic [BEAT_BITS-1:0]  resp_beat;
    logic [BEAT_WIDTH-1:0] resp_data;
    logic                  resp_inv_valid;
    logic [PADDR_SIZE-1:0] resp_inv_paddr;

    modport master (
        input  miss_valid, miss_paddr, miss_way,
        input  resp_ack, resp_valid, resp_beat, resp_data,
        input  resp_inv_valid, resp_inv_paddr,
        output miss_ready, req_valid, req_paddr, req_way
    );

    modport slave (
        output miss_valid, miss_paddr, miss_way,
        output resp_ack, resp_valid, resp_beat, resp_data,
        output resp_inv_valid, resp_inv_paddr,
        input  miss_ready, req_valid, req_paddr, req_way
    );
endinterface

// File: rtl/sargantana_icache_refill_unit.sv
// ---------------------------------------------------------------------------
// sargantana_icache_refill_unit
//
// Instruction-cache refill engine. Accepts one miss at a time, issues a
// line-aligned iFill request, gathers NUM_BEATS beats in any order into a
// line buffer and writes the assembled line into the victim way. Kill, flush
// and coherence invalidation are tracked per miss; PMU strobes and a
// saturating miss-latency counter are exported.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   flush_i             flush: kill plus discard of the current miss
//   kill_i              core kills the pending fetch
//   bus                 miss hand-off and iFill bus (master modport)
//   line_we_o           one-cycle line write strobe
//   line_way_o          write way
//   line_idx_o          set index of the line
//   line_tag_o          tag of the line
//   line_data_o         assembled line, beat b at [b*BEAT_WIDTH +: BEAT_WIDTH]
//   refill_done_o       one-cycle pulse, line available to the core
//   imiss_time_pmu_o    high while a miss is in flight
//   imiss_kill_pmu_o    one-cycle pulse on the first kill of a miss
//   miss_cycles_o       latency of the last completed miss, saturating
// ---------------------------------------------------------------------------
module sargantana_icache_refill_unit #(
    parameter int PADDR_SIZE = 40,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int WAYS       = 4,
    parameter int IDX_BITS   = 7,
    parameter int CNT_WIDTH  = 16,
    localparam int NUM_BEATS   = LINE_WIDTH / BEAT_WIDTH,
    localparam int WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8),
    localparam int TAG_BITS    = PADDR_SIZE - IDX_BITS - OFFSET_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  kill_i,
    sargantana_icache_refill_unit_if.master bus,
    output logic                  line_we_o,
    output logic [WAY_BITS-1:0]   line_way_o,
    output logic [IDX_BITS-1:0]   line_idx_o,
    output logic [TAG_BITS-1:0]   line_tag_o,
    output logic [LINE_WIDTH-1:0] line_data_o,
    output logic                  refill_done_o,
    output logic                  imiss_time_pmu_o,
    output logic                  imiss_kill_pmu_o,
    output logic [CNT_WIDTH-1:0]  miss_cycles_o
);
    localparam int LINE_ADDR_BITS = PADDR_SIZE - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_e;

    state_e                    state_q;
    logic [LINE_ADDR_BITS-1:0] lineAddr_q;
    logic [WAY_BITS-1:0]       way_q;
    logic [NUM_BEATS-1:0]      beatMask_q;
    logic [NUM_BEATS-1:0]      beatMask_d;
    logic                      killed_q;
    logic                      discard_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [CNT_WIDTH-1:0]      missCycles_q;
    logic [LINE_WIDTH-1:0]     line_q;
    logic                      killPmu_q;

    logic                      beatAccept;
    logic [NUM_BEATS-1:0]      beatBit;
    logic                      maskFull;
    logic                      invMatch;
    logic                      killEvent;
    logic                      unusedOffsetBits;

    // The byte offset of incoming addresses is irrelevant to a line refill.
    assign unusedOffsetBits = ^{bus.miss_paddr[OFFSET_BITS-1:0],
                                bus.resp_inv_paddr[OFFSET_BITS-1:0]};

    // Beat bookkeeping and event decode. A beat counts in WAIT, or in REQ
    // when it rides along with the ack. maskFull looks at the mask including
    // this cycle's beat so the last beat moves the FSM on the same edge, which
    // also covers single-beat lines and a final beat arriving with the ack.
    // Beat indices are assumed to stay below NUM_BEATS (power-of-two lines).
    always_comb begin
        beatAccept = bus.resp_valid &&
                     ((state_q == WAIT) || ((state_q == REQ) && bus.resp_ack));
        beatBit    = NUM_BEATS'(1) << bus.resp_beat;
        beatMask_d = beatAccept ? (beatMask_q | beatBit) : beatMask_q;
        maskFull   = &beatMask_d;
        invMatch   = (state_q != IDLE) && bus.resp_inv_valid &&
                     (bus.resp_inv_paddr[PADDR_SIZE-1:OFFSET_BITS] == lineAddr_q);
        killEvent  = (state_q != IDLE) && (kill_i || flush_i);
    end

    // Refill FSM with all per-miss state. Kill/flush/invalidation only act
    // while a line is outstanding, so an IDLE-cycle kill (including the
    // accepting edge) is ignored. The latency counter is loaded with 1 on
    // accept and counts every non-IDLE cycle, saturating at all-ones; its
    // value during WRITE is the reported latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lineAddr_q   <= '0;
            way_q        <= '0;
            beatMask_q   <= '0;
            killed_q     <= 1'b0;
            discard_q    <= 1'b0;
            cnt_q        <= '0;
            missCycles_q <= '0;
            line_q       <= '0;
            killPmu_q    <= 1'b0;
        end else begin
            killPmu_q  <= 1'b0;
            beatMask_q <= beatMask_d;

            if (state_q != IDLE && cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end

            if (beatAccept) begin
                line_q[bus.resp_beat * BEAT_WIDTH +: BEAT_WIDTH] <= bus.resp_data;
            end

            if (killEvent) begin
                killed_q <= 1'b1;
                if (!killed_q) begin
                    killPmu_q <= 1'b1;
                end
            end

            if (((state_q != IDLE) && flush_i) || invMatch) begin
                discard_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.miss_valid) begin
                        lineAddr_q <= bus.miss_paddr[PADDR_SIZE-1:OFFSET_BITS];
                        way_q      <= bus.miss_way;
                        beatMask_q <= '0;
                        killed_q   <= 1'b0;
                        discard_q  <= 1'b0;
                        cnt_q      <= CNT_WIDTH'(1);
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.resp_ack) begin
                        state_q <= maskFull ? WRITE : WAIT;
                    end
                end
                WAIT: begin
                    if (maskFull) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    missCycles_q <= cnt_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode. The write strobe also honours an invalidation hitting
    // the line in the WRITE cycle itself, hence invMatch alongside discard_q.
    always_comb begin
        bus.miss_ready   = (state_q == IDLE);
        bus.req_valid    = (state_q == REQ);
        bus.req_paddr    = {lineAddr_q, {OFFSET_BITS{1'b0}}};
        bus.req_way      = way_q;
        line_we_o        = (state_q == WRITE) && !discard_q && !invMatch;
        refill_done_o    = line_we_o && !killed_q;
        line_way_o       = way_q;
        line_idx_o       = lineAddr_q[IDX_BITS-1:0];
        line_tag_o       = lineAddr_q[LINE_ADDR_BITS-1:IDX_BITS];
        line_data_o      = line_q;
        imiss_time_pmu_o = (state_q != IDLE);
        imiss_kill_pmu_o = killPmu_q;
        miss_cycles_o    = missCycles_q;
    end
endmodule

// File: tb/tb_sargantana_icache_refill_unit.sv
// ---------------------------------------------------------------------------
// tb_sargantana_icache_refill_unit
//
// Directed bench for the icache refill unit with default parameters. Each
// miss pushes its expected line write onto a scoreboard queue; a negedge
// monitor pops and compares whenever the unit strobes line_we_o.
// ---------------------------------------------------------------------------
module tb_sargantana_icache_refill_unit;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         kill_i;
    logic         line_we_o;
    logic [1:0]   line_way_o;
    logic [6:0]   line_idx_o;
    logic [27:0]  line_tag_o;
    logic [255:0] line_data_o;
    logic         refill_done_o;
    logic         imiss_time_pmu_o;
    logic         imiss_kill_pmu_o;
    logic [15:0]  miss_cycles_o;

    int checks     = 0;
    int failures   = 0;
    int writeCount = 0;
    int doneCount  = 0;
    int killCount  = 0;
    int w0, d0, k0;

    typedef struct {
        logic [1:0]   way;
        logic [6:0]   idx;
        logic [27:0]  tag;
        logic [255:0] data;
        logic         done;
    } expWrite_t;

    expWrite_t    expQ[$];
    expWrite_t    mon;
    logic [255:0] expLine;
    logic [63:0]  d1b;

    sargantana_icache_refill_unit_if bus ();

    sargantana_icache_refill_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .kill_i           (kill_i),
        .bus              (bus),
        .line_we_o        (line_we_o),
        .line_way_o       (line_way_o),
        .line_idx_o       (line_idx_o),
        .line_tag_o       (line_tag_o),
        .line_data_o      (line_data_o),
        .refill_done_o    (refill_done_o),
        .imiss_time_pmu_o (imiss_time_pmu_o),
        .imiss_kill_pmu_o (imiss_kill_pmu_o),
        .miss_cycles_o    (miss_cycles_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue a miss, check the request it produces, then ack after ackWait
    // further cycles of REQ.
    task automatic applyStimulus(input logic [39:0] paddr, input logic [1:0] way,
                                 input int ackWait, input logic killAtAccept);
        bus.miss_valid = 1'b1;
        bus.miss_paddr = paddr;
        bus.miss_way   = way;
        kill_i         = killAtAccept;
        tick();
        bus.miss_valid = 1'b0;
        kill_i         = 1'b0;
        @(negedge clk_i);
        checkOutput("req_valid", 256'(bus.req_valid), 256'(1));
        checkOutput("req_paddr", 256'(bus.req_paddr), 256'({paddr[39:5], 5'b0}));
        checkOutput("req_way", 256'(bus.req_way), 256'(way));
        checkOutput("time_pmu", 256'(imiss_time_pmu_o), 256'(1));
        repeat (ackWait) tick();
        bus.resp_ack = 1'b1;
        tick();
        bus.resp_ack = 1'b0;
    endtask

    // Drive one beat for one cycle; the bench line model tracks it.
    task automatic sendBeat(input logic [1:0] beat, input logic [63:0] data);
        bus.resp_valid = 1'b1;
        bus.resp_beat  = beat;
        bus.resp_data  = data;
        expLine[beat*64 +: 64] = data;
        tick();
        bus.resp_valid = 1'b0;
    endtask

    task automatic pushExpect(input logic [39:0] paddr, input logic [1:0] way,
                              input logic done);
        expWrite_t e;
        e.way  = way;
        e.idx  = paddr[11:5];
        e.tag  = paddr[39:12];
        e.data = expLine;
        e.done = done;
        expQ.push_back(e);
    endtask

    task automatic sendLine(input logic [63:0] base);
        for (int b = 0; b < 4; b++) sendBeat(2'(b), base + 64'(b));
    endtask

    // Bounded wait for the unit to return to IDLE.
    task automatic waitIdle();
        for (int i = 0; i < 20; i++) begin
            if (bus.miss_ready) break;
            tick();
        end
        checkOutput("idle_reached", 256'(bus.miss_ready), 256'(1));
    endtask

    task automatic snap();
        w0 = writeCount;
        d0 = doneCount;
        k0 = killCount;
    endtask

    task automatic checkCounts(input string tag, input int w, input int d, input int k);
        checkOutput({tag, "_writes"}, 256'(writeCount - w0), 256'(w));
        checkOutput({tag, "_dones"}, 256'(doneCount - d0), 256'(d));
        checkOutput({tag, "_kills"}, 256'(killCount - k0), 256'(k));
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk_i) begin
        if (refill_done_o) doneCount++;
        if (imiss_kill_pmu_o) killCount++;
        if (refill_done_o && !line_we_o)
            checkOutput("done_without_write", 256'(line_we_o), 256'(1));
        if (line_we_o) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_write", 256'(line_we_o), 256'(0));
            end else begin
                mon = expQ.pop_front();
                checkOutput("sb_way", 256'(line_way_o), 256'(mon.way));
                checkOutput("sb_idx", 256'(line_idx_o), 256'(mon.idx));
                checkOutput("sb_tag", 256'(line_tag_o), 256'(mon.tag));
                checkOutput("sb_data", line_data_o, mon.data);
                checkOutput("sb_done", 256'(refill_done_o), 256'(mon.done));
            end
        end
    end

    initial begin
        rst_i              = 1'b1;
        flush_i            = 1'b0;
        kill_i             = 1'b0;
        bus.miss_valid     = 1'b0;
        bus.miss_paddr     = '0;
        bus.miss_way       = '0;
        bus.resp_ack       = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_beat      = '0;
        bus.resp_data      = '0;
        bus.resp_inv_valid = 1'b0;
        bus.resp_inv_paddr = '0;
        expLine            = '0;
        repeat (3) tick();
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] reset state");
        checkOutput("rst_miss_ready", 256'(bus.miss_ready), 256'(1));
        checkOutput("rst_req_valid", 256'(bus.req_valid), 256'(0));
        checkOutput("rst_line_we", 256'(line_we_o), 256'(0));
        checkOutput("rst_done", 256'(refill_done_o), 256'(0));
        checkOutput("rst_time_pmu", 256'(imiss_time_pmu_o), 256'(0));
        checkOutput("rst_kill_pmu", 256'(imiss_kill_pmu_o), 256'(0));
        checkOutput("rst_miss_cycles", 256'(miss_cycles_o), 256'(0));
        tick();

        $display("[TB] basic refill, in-order beats");
        snap();
        applyStimulus(40'h00_8000_1234, 2'd2, 1, 1'b0);
        sendLine(64'hA1A1_0000_0000_0000);
        pushExpect(40'h00_8000_1234, 2'd2, 1'b1);
        waitIdle();
        checkCounts("basic", 1, 1, 0);
        checkOutput("basic_idx", 256'(line_idx_o), 256'(7'h11));
        checkOutput("basic_tag", 256'(line_tag_o), 256'(28'h0080001));
        checkOutput("basic_miss_cycles", 256'(miss_cycles_o), 256'(7));
        checkOutput("sb_drain_basic", 256'(expQ.size()), 256'(0));

        $display("[TB] out-of-order beats with duplicate, kill on accept edge");
        snap();
        d1b = 64'hB1B1_0000_0000_0011;
        applyStimulus(40'h00_4000_5678, 2'd1, 0, 1'b1);
        sendBeat(2'd3, 64'hB1B1_0000_0000_0003);
        sendBeat(2'd1, 64'hB1B1_0000_0000_0001);
        sendBeat(2'd1, d1b);
        sendBeat(2'd0, 64'hB1B1_0000_0000_0000);
        sendBeat(2'd2, 64'hB1B1_0000_0000_0002);
        pushExpect(40'h00_4000_5678, 2'd1, 1'b1);
        waitIdle();
        checkCounts("reorder", 1, 1, 0);
        checkOutput("reorder_beat1_slice", 256'(line_data_o[127:64]), 256'(d1b));

        $display("[TB] kill twice during WAIT");
        snap();
        applyStimulus(40'h00_1234_5040, 2'd0, 1, 1'b0);
        sendBeat(2'd0, 64'hC1C1_0000_0000_0000);
        kill_i = 1'b1;
        sendBeat(2'd1, 64'hC1C1_0000_0000_0001);
        sendBeat(2'd2, 64'hC1C1_0000_0000_0002);
        kill_i = 1'b0;
        sendBeat(2'd3, 64'hC1C1_0000_0000_0003);
        pushExpect(40'h00_1234_5040, 2'd0, 1'b0);
        waitIdle();
        checkCounts("kill", 1, 0, 1);

        $display("[TB] matching invalidation during WAIT");
        snap();
        applyStimulus(40'h00_8000_1208, 2'd3, 1, 1'b0);
        sendBeat(2'd0, 64'hD1D1_0000_0000_0000);
        bus.resp_inv_valid = 1'b1;
        bus.resp_inv_paddr = 40'h00_8000_1200;
        sendBeat(2'd1, 64'hD1D1_0000_0000_0001);
        bus.resp_inv_valid = 1'b0;
        sendBeat(2'd2, 64'hD1D1_0000_0000_0002);
        sendBeat(2'd3, 64'hD1D1_0000_0000_0003);
        waitIdle();
        checkCounts("inv_wait", 0, 0, 0);

        $display("[TB] matching invalidation in the WRITE cycle");
        snap();
        applyStimulus(40'h00_0ABC_DE60, 2'd1, 1, 1'b0);
        sendLine(64'hE1E1_0000_0000_0000);
        bus.resp_inv_valid = 1'b1;
        bus.resp_inv_paddr = 40'h00_0ABC_DE7F;
        tick();
        bus.resp_inv_valid = 1'b0;
        waitIdle();
        checkCounts("inv_write", 0, 0, 0);

        $display("[TB] invalidation of the neighbouring line");
        snap();
        applyStimulus(40'h00_8000_1234, 2'd2, 1, 1'b0);
        sendBeat(2'd0, 64'hF1F1_0000_0000_0000);
        bus.resp_inv_valid = 1'b1;
        bus.resp_inv_paddr = 40'h00_8000_1200;
        sendBeat(2'd1, 64'hF1F1_0000_0000_0001);
        bus.resp_inv_valid = 1'b0;
        sendBeat(2'd2, 64'hF1F1_0000_0000_0002);
        sendBeat(2'd3, 64'hF1F1_0000_0000_0003);
        pushExpect(40'h00_8000_1234, 2'd2, 1'b1);
        waitIdle();
        checkCounts("inv_other", 1, 1, 0);

        $display("[TB] flush during WAIT");
        snap();
        applyStimulus(40'h00_5555_5580, 2'd3, 1, 1'b0);
        sendBeat(2'd0, 64'h1212_0000_0000_0000);
        flush_i = 1'b1;
        sendBeat(2'd1, 64'h1212_0000_0000_0001);
        flush_i = 1'b0;
        sendBeat(2'd2, 64'h1212_0000_0000_0002);
        sendBeat(2'd3, 64'h1212_0000_0000_0003);
        waitIdle();
        checkCounts("flush", 0, 0, 1);

        $display("[TB] reset in WAIT followed by stray beats");
        snap();
        applyStimulus(40'h00_7777_7700, 2'd2, 1, 1'b0);
        sendBeat(2'd0, 64'h3434_0000_0000_0000);
        sendBeat(2'd1, 64'h3434_0000_0000_0001);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sendBeat(2'd2, 64'h3434_0000_0000_0002);
        sendBeat(2'd3, 64'h3434_0000_0000_0003);
        @(negedge clk_i);
        checkOutput("rst2_miss_ready", 256'(bus.miss_ready), 256'(1));
        checkOutput("rst2_req_valid", 256'(bus.req_valid), 256'(0));
        checkOutput("rst2_req_paddr", 256'(bus.req_paddr), 256'(0));
        checkOutput("rst2_line_data", line_data_o, 256'(0));
        checkOutput("rst2_tag", 256'(line_tag_o), 256'(0));
        checkOutput("rst2_time_pmu", 256'(imiss_time_pmu_o), 256'(0));
        checkOutput("rst2_miss_cycles", 256'(miss_cycles_o), 256'(0));
        tick();
        checkCounts("rst2", 0, 0, 0);

        $display("[TB] ack withheld long enough to saturate the counter");
        snap();
        applyStimulus(40'h00_2468_ACE0, 2'd0, 70000, 1'b0);
        sendLine(64'h5656_0000_0000_0000);
        pushExpect(40'h00_2468_ACE0, 2'd0, 1'b1);
        waitIdle();
        checkCounts("sat", 1, 1, 0);
        checkOutput("sat_miss_cycles", 256'(miss_cycles_o), 256'(16'hFFFF));
        checkOutput("sb_drain_final", 256'(expQ.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
